inst_fetch_queue: RTL and testbench

- Fetch stage directly upstream of the instruction decoder.
- Owns the PC and issues one 32-bit word read at a time to the memory arbiter.
- Buffers fetched {pc, inst} pairs in a small FIFO and presents the head to the decoder through a valid/ready handshake.
- Flushes and restarts on a redirect from branch resolution.

---
 rtl/inst_fetch_queue.sv | 172 +++++++++++++++++
 tb/tb_inst_fetch_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: PC owner and fetch buffer in front of the instruction decoder.
// Issues one word read at a time, queues {pc, inst} pairs and hands the head to
// the decoder over a valid/ready handshake. A redirect flushes the queue and
// restarts fetch; a read already in flight is drained and its data dropped.
// Optional build macro FETCH_JAL_PREDICT_EN: follow JAL targets at fetch time
// and tag those entries with pred_taken.
module inst_fetch_queue #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        pred_taken,
  input  logic        inst_ready
);

  localparam int             PTR_W   = $clog2(QUEUE_DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(QUEUE_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [PTR_W:0]     count_q, count_d;
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;

  logic [31:0]        inst_mem [QUEUE_DEPTH];
  logic [31:0]        pc_mem   [QUEUE_DEPTH];
`ifdef FETCH_JAL_PREDICT_EN
  logic               pred_mem [QUEUE_DEPTH];
  logic               fetch_jal;
`endif

  logic               push;
  logic               pop;
  logic [31:0]        next_pc;

  // Queue handshakes; a redirect cancels both the push and the pop of its cycle.
  always_comb begin
    push = rdy_in && (state_q == S_WAIT) && mem_done && !redirect_valid;
    pop  = rdy_in && inst_valid && inst_ready && !redirect_valid;
  end

  // Address to fetch after the word currently returning from memory.
  always_comb begin
`ifdef FETCH_JAL_PREDICT_EN
    fetch_jal = (mem_data[6:0] == 7'b1101111);
    if (fetch_jal) begin
      next_pc = pc_q + {{11{mem_data[31]}}, mem_data[31], mem_data[19:12],
                        mem_data[20], mem_data[30:21], 1'b0};
    end else begin
      next_pc = pc_q + 32'd4;
    end
`else
    next_pc = pc_q + 32'd4;
`endif
  end

  // Next state of the fetch FSM, PC, memory request and queue pointers.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      count_d = '0;
      head_d  = tail_q;
      // An in-flight read must still complete; remember to throw it away.
      if (state_q == S_WAIT || state_q == S_DISCARD) begin
        if (mem_done) begin
          mem_req_d = 1'b0;
          state_d   = S_IDLE;
        end else begin
          state_d   = S_DISCARD;
        end
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (count_q < DEPTH_C) begin
            mem_req_d  = 1'b1;
            mem_addr_d = pc_q;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_done) begin
            pc_d      = next_pc;
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
        S_DISCARD: begin
          if (mem_done) begin
            mem_req_d = 1'b0;
            state_d   = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
      if (push) tail_d = tail_q + PTR_W'(1);
      if (pop)  head_d = head_q + PTR_W'(1);
      count_d = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
    end
  end

  // Control registers; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
    end else if (rdy_in) begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  // Queue storage is written only on push and carries no reset.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_mem[tail_q] <= mem_data;
      pc_mem[tail_q]   <= pc_q;
`ifdef FETCH_JAL_PREDICT_EN
      pred_mem[tail_q] <= fetch_jal;
`endif
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign inst_valid = (count_q != '0);
  // Head fields read as zero while empty so reset and flush show clean outputs.
  assign inst_out   = inst_valid ? inst_mem[head_q] : 32'd0;
  assign pc_out     = inst_valid ? pc_mem[head_q]   : 32'd0;
`ifdef FETCH_JAL_PREDICT_EN
  assign pred_taken = inst_valid && pred_mem[head_q];
`else
  assign pred_taken = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: randomized and directed stimulus checked every
// cycle against a transaction-level model (entry queue plus a request flag).
module tb_inst_fetch_queue;

  localparam int DEPTH = 4;
`ifdef FETCH_JAL_PREDICT_EN
  localparam bit          JAL_EN   = 1'b1;
  localparam logic [31:0] JAL_NEXT = 32'h20;
`else
  localparam bit          JAL_EN   = 1'b0;
  localparam logic [31:0] JAL_NEXT = 32'h14;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_done = 1'b0;
  logic [31:0] mem_data = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        pred_taken;
  logic        inst_ready = 1'b0;

  inst_fetch_queue #(.QUEUE_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst_out(inst_out), .pc_out(pc_out),
    .pred_taken(pred_taken), .inst_ready(inst_ready)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        pred;
  } ent_t;

  // Reference model: delivered entries, the fetch PC, and one outstanding read.
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_disc;
  logic [31:0] m_addr;

  // Memory responder knobs.
  int lat_cnt = 0, lat_min = 0, lat_max = 0;
  bit nop_mode = 1'b1, jal_at_10 = 1'b0, redir_taken = 1'b0;

  int n_vec = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    if (jal_at_10 && a == 32'h10) return 32'h0100_006F;
    if (nop_mode) return 32'h0000_0013;
    h = (a ^ 32'h5bd1_e995) * 32'h9E37_79B1;
    return {h[31:7], (h[10:8] == 3'd0) ? 7'b1101111 : 7'b0110011};
  endfunction

  function automatic logic is_jal(input logic [31:0] d);
    return JAL_EN && (d[6:0] == 7'h6F);
  endfunction

  // Successor PC: JAL target (J-immediate, sign-extended) when prediction is on.
  function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [31:0] d);
    logic [31:0] imm;
    imm = {{12{d[31]}}, d[19:12], d[20], d[30:21], 1'b0};
    return is_jal(d) ? pc + imm : pc + 32'd4;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_pc = 32'h0; m_out = 1'b0; m_disc = 1'b0; m_addr = 32'h0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    int   sz;
    logic do_pop;
    ent_t e;
    if (!rdy_in) return;
    sz = mq.size();
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
      if (m_out) begin
        if (mem_done) begin m_out = 1'b0; m_disc = 1'b0; end
        else m_disc = 1'b1;
      end
    end else begin
      do_pop = (sz != 0) && inst_ready;
      if (m_out && mem_done) begin
        if (!m_disc) begin
          e.pc = m_pc; e.inst = mem_data; e.pred = is_jal(mem_data);
          mq.push_back(e);
          m_pc = ref_next(m_pc, mem_data);
        end
        m_out = 1'b0; m_disc = 1'b0;
      end else if (!m_out && sz < DEPTH) begin
        m_out = 1'b1; m_addr = m_pc;
      end
      if (do_pop) mq.delete(0);
    end
  endtask

  task automatic check_outputs();
    check("mem_req", mem_req, m_out);
    if (m_out) check("mem_addr", mem_addr, m_addr);
    check("inst_valid", inst_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      check("pc_out", pc_out, mq[0].pc);
      check("inst_out", inst_out, mq[0].inst);
      check("pred_taken", pred_taken, mq[0].pred);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_inst_valid"}, inst_valid, 0);
    check({tag, "_inst_out"}, inst_out, 0);
    check({tag, "_pc_out"}, pc_out, 0);
    check({tag, "_pred_taken"}, pred_taken, 0);
  endtask

  // One cycle: check at the falling edge, then drive inputs and step the model.
  // redir_mode: 0 none, 1 always, 2 only while a request is outstanding.
  task automatic step(input logic rdy, input logic rdy_dec, input int redir_mode,
                      input logic [31:0] rpc);
    @(negedge clk_in);
    check_outputs();
    rdy_in         = rdy;
    inst_ready     = rdy_dec;
    redirect_valid = (redir_mode == 1) || (redir_mode == 2 && mem_req);
    redir_taken    = redirect_valid;
    redirect_pc    = rpc;
    if (mem_req && lat_cnt == 0) begin
      mem_done = 1'b1;
      mem_data = mem_word(mem_addr);
      lat_cnt  = $urandom_range(lat_max, lat_min);
    end else begin
      mem_done = 1'b0;
      mem_data = $urandom;
      if (mem_req) lat_cnt--;
    end
    model_step();
  endtask

  task automatic wait_addr(input logic [31:0] a, input logic rdy_dec, input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step(1'b1, rdy_dec, 0, 32'h0);
      if (mem_req && mem_addr == a) found = 1'b1;
    end
    check(tag, found, 1);
  endtask

  initial begin
    model_reset();
    #1 rst_in = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk_in);
    rst_in = 1'b0;

    // Start fetching at 0x100, then reset while the read is outstanding.
    lat_min = 3; lat_max = 3;
    step(1'b1, 1'b0, 1, 32'h100);
    wait_addr(32'h100, 1'b0, "req_0x100");
    #2 rst_in = 1'b1;
    #1 check_reset_outputs("reset_mid_wait");
    @(negedge clk_in);
    rst_in = 1'b0; mem_done = 1'b0; rdy_in = 1'b0; lat_cnt = 0;
    model_reset();

    // Immediate memory, decoder stalled: queue fills from 0x0 and fetch stops.
    lat_min = 0; lat_max = 0;
    wait_addr(32'h0, 1'b0, "seq_addr_0");
    wait_addr(32'h4, 1'b0, "seq_addr_4");
    wait_addr(32'h8, 1'b0, "seq_addr_8");
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 0, 32'h0);
    check("full_no_req", mem_req, 0);
    check("full_head_pc", pc_out, 32'h0);
    check("full_head_inst", inst_out, 32'h13);
    step(1'b1, 1'b1, 0, 32'h0);
    wait_addr(32'h10, 1'b0, "refill_addr");

    // Redirect while waiting on 0x8; the late word must be dropped.
    step(1'b1, 1'b1, 1, 32'h0);
    lat_min = 3; lat_max = 3;
    wait_addr(32'h8, 1'b0, "wait_on_8");
    step(1'b1, 1'b0, 1, 32'h200);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 0, 32'h0);
    check("redir_head_valid", inst_valid, 1);
    check("redir_head_pc", pc_out, 32'h200);

    // Redirect in the same cycle as mem_done.
    lat_min = 0; lat_max = 0; lat_cnt = 0;
    step(1'b1, 1'b1, 1, 32'h300);
    redir_taken = 1'b0;
    for (int i = 0; i < 10 && !redir_taken; i++) step(1'b1, 1'b0, 2, 32'h400);
    check("redir_with_done", redir_taken, 1);
    wait_addr(32'h400, 1'b0, "redir_done_addr");

    // Redirect together with a pop from a three-entry queue.
    for (int i = 0; i < 40 && mq.size() != 3; i++) step(1'b1, 1'b0, 0, 32'h0);
    check("three_entries", inst_valid, 1);
    step(1'b1, 1'b1, 1, 32'h500);
    step(1'b1, 1'b0, 0, 32'h0);
    check("flush_valid", inst_valid, 0);

    // PC wraps past the top of the address space.
    step(1'b1, 1'b1, 1, 32'hFFFF_FFFC);
    wait_addr(32'hFFFF_FFFC, 1'b0, "wrap_top");
    wait_addr(32'h0, 1'b0, "wrap_zero");

    // rdy_in low for 5 cycles mid-WAIT while memory keeps answering.
    lat_min = 6; lat_max = 6;
    step(1'b1, 1'b1, 1, 32'h600);
    wait_addr(32'h604, 1'b0, "freeze_req_seen");
    lat_cnt = 0; lat_min = 0; lat_max = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0, 32'h0);
    check("freeze_req", mem_req, 1);
    check("freeze_addr", mem_addr, 32'h604);

    // JAL at 0x10 (jal x0,+16).
    jal_at_10 = 1'b1;
    step(1'b1, 1'b0, 1, 32'h10);
    wait_addr(32'h10, 1'b0, "jal_req");
    wait_addr(JAL_NEXT, 1'b0, "jal_next_addr");
    check("jal_head_pc", pc_out, 32'h10);
    check("jal_head_inst", inst_out, 32'h0100_006F);
    check("jal_pred", pred_taken, JAL_EN);
    jal_at_10 = 1'b0;

    // Random traffic.
    nop_mode = 1'b0; lat_min = 0; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] r;
      r = $urandom;
      step($urandom_range(99, 0) < 85, $urandom_range(1, 0) == 1,
           ($urandom_range(99, 0) < 3) ? 1 : 0, {r[31:2], 2'b00});
    end
    step(1'b1, 1'b0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
